instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  IF stage of the 5-stage RV32I pipeline; sits directly upstream of the IF/ID pipeline register.
//  Owns the PC and issues instruction-memory requests over a valid/ready request, valid-only response interface.
//  Delivers {instruction, pc_current, pc_next} to IF/ID with a valid flag, honouring stall and branch redirect.
//  At most one memory request outstanding; a 1-entry skid register absorbs a response that arrives while stalled.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC of the first fetch after reset
//  XLEN      32             address/instruction width (only 32 supported)
// PORTS
//  clk             in   1     clock, all state on posedge
//  resetn          in   1     reset, asynchronous, ACTIVE-HIGH (1 = in reset) despite the name
//  imem_req_valid  out  1     fetch request valid
//  imem_req_ready  in   1     memory accepts request this cycle
//  imem_req_addr   out  32    fetch address (= pc)
//  imem_rsp_valid  in   1     response data valid (exactly one per accepted request, >=1 cycle later)
//  imem_rsp_data   in   32    instruction word
//  redirect_valid  in   1     taken branch/jump from EX (same signal as branch_or_not to IF/ID)
//  redirect_pc     in   32    redirect target
//  stall           in   1     hazard unit: IF/ID must not advance
//  instr_valid     out  1     output slot holds a live instruction
//  instruction_out out  32    instruction to IF/ID
//  pc_current_out  out  32    address of instruction_out
//  pc_next_out     out  32    pc_current_out + 4 (mod 2^32)
// BEHAVIOUR
//  Reset (async assert): pc=RESET_PC, state=REQ, all outputs 0, skid empty. Takes effect immediately, mid-request included; imem shares reset.
//  FSM: REQ, WAIT, HOLD, DRAIN.
//  - REQ: imem_req_valid=1 unless redirect_valid. Handshake -> WAIT. Redirect: pc<=redirect_pc, no request this cycle, stay REQ.
//  - WAIT: on rsp_valid with slot free (!instr_valid || !stall): load slot {rsp_data, pc, pc+4}, pc<=pc+4, ->REQ.
//    On rsp_valid with stall && instr_valid: capture into skid, pc<=pc+4, ->HOLD.
//  - HOLD: when !stall: skid -> slot, ->REQ. No new request while in HOLD.
//  - Redirect in WAIT: pc<=redirect_pc; rsp_valid same cycle -> discard, ->REQ; else ->DRAIN.
//  - DRAIN: discard next response, ->REQ. A redirect here updates pc only.
//  - Redirect in HOLD: drop skid, pc<=redirect_pc, ->REQ.
//  Redirect always clears instr_valid next cycle and zeroes the slot; redirect beats stall.
//  Slot holds its value while stall && instr_valid. When consumed without refill, instr_valid<=0 and data fields are held.
//  Latency: request handshake -> instr_valid = rsp latency + 1 cycle. Steady state is 1 instr per 2 cycles with a 1-cycle memory.
//  pc+4 wraps 32'hFFFF_FFFC -> 0. redirect_pc[1:0] is forced to 2'b00.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined: adds outputs perf_fetched[31:0] and perf_redirects[31:0].
//    perf_fetched counts slot loads; perf_redirects counts cycles with redirect_valid.
//    Both reset to 0, wrap at 2^32.
//  Undefined: the ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  fetch_pkg: fetch_state_e {REQ,WAIT,HOLD,DRAIN}, XLEN, PC_INC=32'd4, fetch_slot_t {instr, pc, pc_next}.
//  Sub-module fetch_skid_reg: 1-entry fetch_slot_t holding register with load/drop/valid.
// TESTING
//  1. Reset release, imem 1-cycle latency, words A,B,C -> slot shows (A,0,4), (B,4,8), (C,8,12); req addrs 0,4,8.
//  2. stall=1 for 3 cycles while slot=(A,0,4) and rsp B arrives -> slot holds A, state HOLD, no req.
//     stall=0 -> slot=(B,4,8) next cycle.
//  3. redirect_valid with redirect_pc=0x100 in WAIT; stale rsp arrives 2 cycles later -> discarded.
//     Next req addr 0x100; instr_valid=0 until the 0x100 response.
//  4. redirect and rsp_valid in the same WAIT cycle -> rsp dropped, next cycle REQ at redirect_pc.
//  5. imem_req_ready held low 5 cycles -> req_valid and addr stable; redirect mid-wait changes addr with req_valid=0 for that cycle.
//  6. Async reset asserted in WAIT at pc=0x40 -> outputs 0 without a clock edge; after release first req addr=RESET_PC.
//     With FETCH_PERF_CNT_EN also check perf_fetched after 10 loads = 10.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction fetch stage.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;
  } fetch_slot_t;

endpackage

// File: rtl/fetch_skid_reg.sv
// One-entry holding register for a fetch response that lands while IF/ID is stalled.
module fetch_skid_reg
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        drop,
  input  fetch_slot_t d,
  output logic        valid,
  output fetch_slot_t q
);

  // Capture on load; drop (pop or flush) empties the entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (drop) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// IF stage: owns the PC, issues single-outstanding imem requests and feeds IF/ID.
// Optional build macro FETCH_PERF_CNT_EN adds perf_fetched / perf_redirects counters.
// Note: resetn is active-high despite its name.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          XLEN     = 32
)(
  input  logic            clk,
  input  logic            resetn,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            instr_valid,
  output logic [XLEN-1:0] instruction_out,
  output logic [XLEN-1:0] pc_current_out,
  output logic [XLEN-1:0] pc_next_out
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_redirects
`endif
);

  logic            rst;
  fetch_state_e    state, state_nxt;
  logic [XLEN-1:0] pc, pc_plus4, redir_pc;
  fetch_slot_t     slot, skid_q;
  logic            slot_vld, slot_free, skid_vld;
  logic            req_issue, load_rsp, skid_load, skid_pop, pc_step;

  assign rst       = resetn;
  assign pc_plus4  = pc + PC_INC;
  assign redir_pc  = redirect_pc & ~32'h3;
  assign slot_free = !slot_vld || !stall;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= REQ;
    else     state <= state_nxt;
  end

  // Next-state: redirect always wins; WAIT with a stalled full slot parks in HOLD.
  always_comb begin
    state_nxt = state;
    case (state)
      REQ:   if (!redirect_valid && imem_req_ready) state_nxt = WAIT;
      WAIT: begin
        if (redirect_valid)      state_nxt = imem_rsp_valid ? REQ : DRAIN;
        else if (imem_rsp_valid) state_nxt = slot_free ? REQ : HOLD;
      end
      HOLD:  if (redirect_valid || !stall) state_nxt = REQ;
      DRAIN: if (imem_rsp_valid) state_nxt = REQ;
      default: state_nxt = REQ;
    endcase
  end

  // Per-state control strobes for the datapath.
  always_comb begin
    req_issue = (state == REQ) && !redirect_valid;
    load_rsp  = (state == WAIT) && imem_rsp_valid && !redirect_valid && slot_free;
    skid_load = (state == WAIT) && imem_rsp_valid && !redirect_valid && !slot_free;
    skid_pop  = (state == HOLD) && !redirect_valid && !stall && skid_vld;
    pc_step   = load_rsp || skid_load;
  end

  // Request is masked during reset so every output reads 0 immediately.
  assign imem_req_valid = req_issue && !rst;
  assign imem_req_addr  = pc;

  // PC: redirect target, otherwise advance once the response is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 pc <= RESET_PC;
    else if (redirect_valid) pc <= redir_pc;
    else if (pc_step)        pc <= pc_plus4;
  end

  fetch_skid_reg u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .drop  (redirect_valid || skid_pop),
    .d     ('{instr: imem_rsp_data, pc: pc, pc_next: pc_plus4}),
    .valid (skid_vld),
    .q     (skid_q)
  );

  // Output slot: flush on redirect, refill from memory or skid, else hold/consume.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot     <= '0;
      slot_vld <= 1'b0;
    end else if (redirect_valid) begin
      slot     <= '0;
      slot_vld <= 1'b0;
    end else if (load_rsp) begin
      slot     <= '{instr: imem_rsp_data, pc: pc, pc_next: pc_plus4};
      slot_vld <= 1'b1;
    end else if (skid_pop) begin
      slot     <= skid_q;
      slot_vld <= 1'b1;
    end else if (!stall) begin
      slot_vld <= 1'b0;
    end
  end

  assign instr_valid     = slot_vld;
  assign instruction_out = slot.instr;
  assign pc_current_out  = slot.pc;
  assign pc_next_out     = slot.pc_next;

`ifdef FETCH_PERF_CNT_EN
  // Slot loads and redirect cycles, free-running with natural wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched   <= '0;
      perf_redirects <= '0;
    end else begin
      if (load_rsp || skid_pop) perf_fetched   <= perf_fetched + 32'd1;
      if (redirect_valid)       perf_redirects <= perf_redirects + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: table-driven start-up/stall vectors, hand sequences
// for redirect/reset corners, and a request/delivery scoreboard throughout.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        instr_valid;
  logic [31:0] instruction_out, pc_current_out, pc_next_out;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_redirects;
`endif

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .XLEN(32)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .stall           (stall),
    .instr_valid     (instr_valid),
    .instruction_out (instruction_out),
    .pc_current_out  (pc_current_out),
    .pc_next_out     (pc_next_out)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched    (perf_fetched),
    .perf_redirects  (perf_redirects)
`endif
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_next;
  } slot_t;

  typedef struct {
    logic        stall;
    logic        ready;
    logic        exp_req;
    logic        exp_iv;
    logic [31:0] exp_pc;
  } vec_t;

  int          n_chk = 0;
  int          n_pass = 0;
  slot_t       sb[$];
  logic [31:0] exp_addr;
  bit          pend;
  int          pend_cnt;
  int          lat = 1;
  logic [31:0] pend_data;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b want %b", name, act, exp);
  endtask

  // Start of a cycle (just after negedge): advance the memory model, let outputs settle.
  task automatic pre();
    imem_rsp_valid = 1'b0;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = pend_data;
        pend           = 1'b0;
      end
    end
    #1;
  endtask

  // Scoreboard for the upcoming posedge, then advance to the next negedge.
  task automatic post();
    slot_t e;
    if (instr_valid && !stall && !redirect_valid) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL deliver: unexpected pc %h, nothing outstanding", pc_current_out);
      end else begin
        e = sb.pop_front();
        chk("deliver_instr", instruction_out, e.instr);
        chk("deliver_pc", pc_current_out, e.pc);
        chk("deliver_pc_next", pc_next_out, e.pc_next);
      end
    end
    if (redirect_valid) begin
      sb.delete();
      exp_addr = redirect_pc & ~32'h3;
    end
    if (imem_req_valid && imem_req_ready) begin
      chk("req_addr", imem_req_addr, exp_addr);
      sb.push_back('{word(exp_addr), exp_addr, exp_addr + 32'd4});
      pend      = 1'b1;
      pend_cnt  = lat;
      pend_data = word(imem_req_addr);
      exp_addr  = exp_addr + 32'd4;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vec[14];
    int   n_loads;
    bit   found;

    // Start-up fetches A,B,C then a 3-cycle stall with a response landing in the skid.
    vec[0]  = '{0, 1, 1, 0, 32'h0};
    vec[1]  = '{0, 1, 0, 0, 32'h0};
    vec[2]  = '{0, 1, 1, 1, 32'h0};
    vec[3]  = '{0, 1, 0, 0, 32'h0};
    vec[4]  = '{0, 1, 1, 1, 32'h4};
    vec[5]  = '{0, 1, 0, 0, 32'h0};
    vec[6]  = '{0, 1, 1, 1, 32'h8};
    vec[7]  = '{0, 1, 0, 0, 32'h0};
    vec[8]  = '{1, 1, 1, 1, 32'hC};
    vec[9]  = '{1, 1, 0, 1, 32'hC};
    vec[10] = '{1, 1, 0, 1, 32'hC};
    vec[11] = '{0, 1, 0, 1, 32'hC};
    vec[12] = '{0, 1, 1, 1, 32'h10};
    vec[13] = '{0, 1, 0, 0, 32'h0};

    resetn = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    pend = 1'b0; exp_addr = 32'h0;

    @(negedge clk);
    chk1("rst_req_valid", imem_req_valid, 1'b0);
    chk1("rst_instr_valid", instr_valid, 1'b0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_pc_next", pc_next_out, 32'h0);
    resetn = 1'b0;

    for (int i = 0; i < 14; i++) begin
      stall = vec[i].stall;
      imem_req_ready = vec[i].ready;
      pre();
      chk1($sformatf("vec%0d_req_valid", i), imem_req_valid, vec[i].exp_req);
      chk1($sformatf("vec%0d_instr_valid", i), instr_valid, vec[i].exp_iv);
      if (vec[i].exp_iv) chk($sformatf("vec%0d_pc", i), pc_current_out, vec[i].exp_pc);
      post();
    end
    stall = 1'b0;

    // Redirect while WAIT, stale response two cycles later must be discarded.
    lat = 3;
    pre(); post();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    pre(); post();
    redirect_valid = 1'b0;
    pre(); chk1("t3_drain_req", imem_req_valid, 1'b0); chk1("t3_drain_iv", instr_valid, 1'b0); post();
    pre(); chk1("t3_stale_req", imem_req_valid, 1'b0); chk1("t3_stale_iv", instr_valid, 1'b0); post();
    lat = 1;
    pre();
    chk1("t3_after_stale_iv", instr_valid, 1'b0);
    chk1("t3_req_valid", imem_req_valid, 1'b1);
    chk("t3_req_addr", imem_req_addr, 32'h100);
    post();
    pre(); chk1("t3_wait_iv", instr_valid, 1'b0); post();
    pre(); chk1("t3_new_iv", instr_valid, 1'b1); chk("t3_new_pc", pc_current_out, 32'h100); post();

    // Redirect coincident with a response: response dropped, next request at target.
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    pre(); post();
    redirect_valid = 1'b0;
    pre();
    chk1("t4_iv", instr_valid, 1'b0);
    chk1("t4_req_valid", imem_req_valid, 1'b1);
    chk("t4_req_addr", imem_req_addr, 32'h200);
    post();
    pre(); post();

    // Back-pressure: request held stable, redirect mid-wait re-targets it.
    for (int i = 0; i < 5; i++) begin
      imem_req_ready = 1'b0;
      redirect_valid = (i == 2);
      redirect_pc    = 32'h300;
      pre();
      if (i == 0) chk("t5_first_pc", pc_current_out, 32'h200);
      chk1($sformatf("t5_req_valid_%0d", i), imem_req_valid, i != 2);
      if (i != 2) chk($sformatf("t5_req_addr_%0d", i), imem_req_addr, (i < 2) ? 32'h204 : 32'h300);
      post();
    end
    redirect_valid = 1'b0; imem_req_ready = 1'b1;
    pre(); post();
    pre(); post();
    pre(); chk("t5_pc", pc_current_out, 32'h300); post();

    // Async reset in WAIT at pc 0x40 with a live slot.
    pre(); post();
    redirect_valid = 1'b1; redirect_pc = 32'h3C;
    pre(); post();
    redirect_valid = 1'b0;
    pre(); post();
    pre(); post();
    stall = 1'b1; lat = 3;
    pre(); chk1("t6_pre_iv", instr_valid, 1'b1); chk("t6_pre_pc", pc_current_out, 32'h3C); post();
    pre();
    chk("t6_wait_addr", imem_req_addr, 32'h40);
    #2 resetn = 1'b1;
    #1;
    chk1("t6_rst_req_valid", imem_req_valid, 1'b0);
    chk("t6_rst_req_addr", imem_req_addr, 32'h0);
    chk1("t6_rst_iv", instr_valid, 1'b0);
    chk("t6_rst_instr", instruction_out, 32'h0);
    chk("t6_rst_pc", pc_current_out, 32'h0);
    chk("t6_rst_pc_next", pc_next_out, 32'h0);
    sb.delete(); exp_addr = 32'h0; pend = 1'b0; imem_rsp_valid = 1'b0;
    stall = 1'b0; lat = 1;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b0;
    pre();
    chk1("t6_first_req_valid", imem_req_valid, 1'b1);
    chk("t6_first_req_addr", imem_req_addr, 32'h0);
    post();

    // Ten loads since reset.
    n_loads = 0;
    for (int i = 0; i < 100 && n_loads < 10; i++) begin
      pre();
      if (imem_rsp_valid) n_loads++;
      post();
    end
    chk("t6_load_budget", n_loads, 32'd10);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetched_10", perf_fetched, 32'd10);
    chk("perf_redirects_0", perf_redirects, 32'd0);
`endif

    // PC wrap at the top of the address space; low redirect bits ignored.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    pre(); post();
    redirect_valid = 1'b0;
`ifdef FETCH_PERF_CNT_EN
    chk("perf_redirects_1", perf_redirects, 32'd1);
`endif
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      pre();
      if (instr_valid && pc_current_out == 32'hFFFF_FFFC) begin
        found = 1'b1;
        chk("t7_wrap_pc_next", pc_next_out, 32'h0);
      end
      post();
    end
    if (!found) begin
      n_chk++;
      $display("FAIL t7_wrap_timeout: pc %h never delivered, want fffffffc", 32'hFFFF_FFFC);
    end
    for (int i = 0; i < 4; i++) begin
      pre(); post();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
